// File: rtl/alu_share_arbiter_if.sv
// Request, response and shared-ALU signals of the two-requester ALU arbiter.
// slave is the arbiter view; master is the requester/ALU view.
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_zero;
  logic             rsp0_err;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_zero;
  logic             rsp1_err;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters:
// accept (IDLE) -> registered execute (EXEC) -> held response (RESP).
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input logic                clk,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [OPW-1:0] OP_AND = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_OR  = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_SLT = OPW'(4'b0111);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       req_ready_c;
  logic             win;
  logic             op_legal;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  // Lone requester wins outright; on contention the pointer decides.
  assign win = (req_valid == 2'b11) ? ptr_q : req_valid[1];

  always_comb begin
    case (alu_ctrl_q)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready[grant_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    result_d    = result_q;
    zero_d      = zero_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_c = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready_c = win ? 2'b10 : 2'b01;
          grant_d     = win;
          alu_a_d     = win ? bus.req1_a  : bus.req0_a;
          alu_b_d     = win ? bus.req1_b  : bus.req0_b;
          alu_ctrl_d  = win ? bus.req1_op : bus.req0_op;
        end
      end
      EXEC: begin
        // Illegal codes never trust the ALU output.
        result_d             = op_legal ? bus.alu_result : '0;
        zero_d               = op_legal & bus.alu_zero;
        err_d                = ~op_legal;
        rsp_valid_d[grant_q] = 1'b1;
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = 2'b00;
          ptr_d       = ~grant_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= 1'b0;
      ptr_q       <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req0_ready  = req_ready_c[0];
  assign bus.req1_ready  = req_ready_c[1];
  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = result_q;
  assign bus.rsp1_result = result_q;
  assign bus.rsp0_zero   = zero_q;
  assign bus.rsp1_zero   = zero_q;
  assign bus.rsp0_err    = err_q;
  assign bus.rsp1_err    = err_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_ctrl    = alu_ctrl_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: vector table, hand-written reset/contention
// sequences, then random traffic against a transaction-level model.
module tb_alu_share_arbiter;
  localparam int unsigned W  = 32;
  localparam int unsigned OW = 4;

  typedef struct {
    logic          id;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [OW-1:0] op;
    logic [W-1:0]  er;
    logic          ez;
    logic          ee;
    int            hold;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_share_arbiter_if #(.WIDTH(W), .OPW(OW)) bus ();
  alu_share_arbiter #(.WIDTH(W), .OPW(OW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Shared ALU; illegal codes return junk that the arbiter must discard.
  always_comb begin
    bus.alu_result = 32'hDEAD_BEEF;
    case (bus.alu_ctrl)
      4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
      4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
      4'b0111: bus.alu_result = (bus.alu_a < bus.alu_b) ? 32'd1 : 32'd0;
      default: ;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0) || (bus.alu_result == 32'hDEAD_BEEF);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void ref_op(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic z, output logic e);
    e = 1'b0;
    case (op)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0111: r = (a < b) ? 32'd1 : 32'd0;
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    z = !e && (r == 32'd0);
  endfunction

  function automatic vec_t mk(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op,
                              input logic [W-1:0] er, input logic ez, input logic ee, input int hold);
    vec_t v;
    v.id = id; v.a = a; v.b = b; v.op = op; v.er = er; v.ez = ez; v.ee = ee; v.hold = hold;
    return v;
  endfunction

  function automatic logic [1:0] ready_vec();
    return {bus.req1_ready, bus.req0_ready};
  endfunction
  function automatic logic [1:0] rspv_vec();
    return {bus.rsp1_valid, bus.rsp0_valid};
  endfunction
  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  task automatic set_req(input logic id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op);
    if (id) begin bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; end
    else    begin bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; end
  endtask

  task automatic clear_inputs();
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [W-1:0] r, input logic z, input logic e);
    chk({tag, "_result"}, id ? bus.rsp1_result : bus.rsp0_result, r);
    chk({tag, "_zero"},   id ? bus.rsp1_zero   : bus.rsp0_zero,   z);
    chk({tag, "_err"},    id ? bus.rsp1_err    : bus.rsp0_err,    e);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, ready_vec(), 2'b00);
    chk({tag, "_rspv"},  rspv_vec(), 2'b00);
    check_rsp({tag, "_r0"}, 1'b0, '0, 1'b0, 1'b0);
    check_rsp({tag, "_r1"}, 1'b1, '0, 1'b0, 1'b0);
    chk({tag, "_alu_a"},    bus.alu_a, '0);
    chk({tag, "_alu_b"},    bus.alu_b, '0);
    chk({tag, "_alu_ctrl"}, bus.alu_ctrl, '0);
  endtask

  // One operation on an otherwise idle block; the other requester
  // pokes valid and rsp_ready during backpressure and must be ignored.
  task automatic single_op(input vec_t v);
    @(negedge clk);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    set_req(v.id, 1'b1, v.a, v.b, v.op);
    #1 chk("tbl_ready", ready_vec(), onehot(v.id));
    @(negedge clk);
    set_req(v.id, 1'b0, '0, '0, '0);
    #1 chk("tbl_exec_ready", ready_vec(), 2'b00);
    chk("tbl_exec_rspv", rspv_vec(), 2'b00);
    chk("tbl_alu_a", bus.alu_a, v.a);
    chk("tbl_alu_b", bus.alu_b, v.b);
    chk("tbl_alu_ctrl", bus.alu_ctrl, v.op);
    for (int i = 0; i <= v.hold; i++) begin
      @(negedge clk);
      if (i > 0) begin
        set_req(!v.id, 1'b1, $urandom(), $urandom(), 4'b0010);
        if (v.id) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
      end
      #1 chk("tbl_rspv", rspv_vec(), onehot(v.id));
      chk("tbl_hold_ready", ready_vec(), 2'b00);
      check_rsp("tbl", v.id, v.er, v.ez, v.ee);
    end
    @(negedge clk);
    set_req(!v.id, 1'b0, '0, '0, '0);
    if (v.id) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
    #1 chk("tbl_done_rspv", rspv_vec(), onehot(v.id));
    chk("tbl_done_ready", ready_vec(), 2'b00);
    @(negedge clk);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    #1 chk("tbl_after_rspv", rspv_vec(), 2'b00);
  endtask

  vec_t tbl[11];

  // random-phase model state
  logic          hv[2];
  logic [W-1:0]  ha[2];
  logic [W-1:0]  hb[2];
  logic [OW-1:0] hop[2];
  logic          outst, owner, prio, winner;
  int            age;
  logic [W-1:0]  ea, eb, er;
  logic [OW-1:0] eop;
  logic          ez, ee;
  logic [1:0]    exp_rdy, rr;

  initial begin
    logic q_grants[$];
    int   got;
    logic acc0, acc1;
    logic [3:0] legal_ops [5];
    legal_ops[0] = 4'b0010; legal_ops[1] = 4'b0110; legal_ops[2] = 4'b0000;
    legal_ops[3] = 4'b0001; legal_ops[4] = 4'b0111;

    tbl[0]  = mk(1'b0, 32'd5,          32'd7,          4'b0010, 32'd12,         1'b0, 1'b0, 0);
    tbl[1]  = mk(1'b1, 32'd9,          32'd9,          4'b0110, 32'd0,          1'b1, 1'b0, 1);
    tbl[2]  = mk(1'b0, 32'h0000_FF00,  32'h0000_0FF0,  4'b0000, 32'h0000_0F00,  1'b0, 1'b0, 5);
    tbl[3]  = mk(1'b0, 32'd1,          32'd2,          4'b1111, 32'd0,          1'b0, 1'b1, 0);
    tbl[4]  = mk(1'b0, 32'h0000_00F0,  32'h0000_000F,  4'b0001, 32'h0000_00FF,  1'b0, 1'b0, 0);
    tbl[5]  = mk(1'b1, 32'd3,          32'd4,          4'b0111, 32'd1,          1'b0, 1'b0, 2);
    tbl[6]  = mk(1'b1, 32'hFFFF_FFFF,  32'd1,          4'b0111, 32'd0,          1'b1, 1'b0, 0);
    tbl[7]  = mk(1'b1, 32'd3,          32'd5,          4'b0110, 32'hFFFF_FFFE,  1'b0, 1'b0, 0);
    tbl[8]  = mk(1'b0, 32'hFFFF_FFFF,  32'd1,          4'b0010, 32'd0,          1'b1, 1'b0, 0);
    tbl[9]  = mk(1'b1, 32'd0,          32'd0,          4'b0011, 32'd0,          1'b0, 1'b1, 1);
    tbl[10] = mk(1'b0, 32'hA5A5_A5A5,  32'h5A5A_5A5A,  4'b0000, 32'd0,          1'b1, 1'b0, 0);

    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");

    // Contention straight out of reset: grants must alternate 0,1,0,1.
    @(negedge clk);
    reset = 1'b0;
    set_req(1'b0, 1'b1, 32'h0000_00F0, 32'h0000_000F, 4'b0001);
    set_req(1'b1, 1'b1, 32'd3, 32'd4, 4'b0111);
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    for (int c = 0; c < 40 && q_grants.size() < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 0) chk("cont_first", ready_vec(), 2'b01);
      if (bus.req0_ready) q_grants.push_back(1'b0);
      if (bus.req1_ready) q_grants.push_back(1'b1);
      if (bus.rsp0_valid) chk("cont_r0", bus.rsp0_result, 32'h0000_00FF);
      if (bus.rsp1_valid) chk("cont_r1", bus.rsp1_result, 32'd1);
    end
    chk("cont_count", q_grants.size(), 4);
    for (int i = 0; i < q_grants.size(); i++) chk("cont_grant", q_grants[i], (i % 2 == 1));
    @(negedge clk);
    clear_inputs();
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (4) @(negedge clk);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

    foreach (tbl[i]) single_op(tbl[i]);

    // Reset during EXEC; pointer (last served req0) must return to req0.
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'd1, 32'd1, 4'b0010);
    #1 chk("rst1_acc", ready_vec(), 2'b01);
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    #1 chk("rst1_in_exec", bus.alu_a, 32'd1);
    @(negedge clk);
    #1 check_all_zero("rst1");
    @(negedge clk);
    reset = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1 chk("rst1_no_rsp", rspv_vec(), 2'b00);
    end
    @(negedge clk);
    set_req(1'b0, 1'b1, 32'h0000_000C, 32'h0000_000A, 4'b0000);
    set_req(1'b1, 1'b1, 32'd2, 32'd3, 4'b0010);
    got = 0; acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (acc0) bus.req0_valid = 1'b0;
      if (acc1) bus.req1_valid = 1'b0;
      #1;
      if (c == 0) chk("rst1_prio", ready_vec(), 2'b01);
      if (bus.req0_ready) acc0 = 1'b1;
      if (bus.req1_ready) acc1 = 1'b1;
      if (bus.rsp0_valid) begin chk("rst1_r0", bus.rsp0_result, 32'd8); got++; end
      if (bus.rsp1_valid) begin chk("rst1_r1", bus.rsp1_result, 32'd5); got++; end
    end
    chk("rst1_done", got, 2);
    @(negedge clk);
    clear_inputs();

    // Reset while a response is held; req1 alone is then taken at once.
    @(negedge clk);
    set_req(1'b1, 1'b1, 32'd10, 32'd3, 4'b0110);
    #1 chk("rst2_acc", ready_vec(), 2'b10);
    @(negedge clk);
    set_req(1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    #1 chk("rst2_resp", rspv_vec(), 2'b10);
    chk("rst2_result", bus.rsp1_result, 32'd7);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 check_all_zero("rst2");
    @(negedge clk);
    reset = 1'b0;
    bus.rsp1_ready = 1'b1;
    set_req(1'b1, 1'b1, 32'd6, 32'd6, 4'b0001);
    #1 chk("rst2_req1_now", ready_vec(), 2'b10);
    @(negedge clk);
    set_req(1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    #1 chk("rst2_rspv", rspv_vec(), 2'b10);
    chk("rst2_r1", bus.rsp1_result, 32'd6);
    @(negedge clk);
    clear_inputs();

    // Random traffic against the transaction-level model.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    hv[0] = 1'b0; hv[1] = 1'b0;
    outst = 1'b0; owner = 1'b0; prio = 1'b0; age = 0;
    ea = '0; eb = '0; eop = '0; er = '0; ez = 1'b0; ee = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!hv[i] && $urandom_range(0, 2) != 0) begin
          hv[i]  = 1'b1;
          ha[i]  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom());
          hb[i]  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom());
          hop[i] = ($urandom_range(0, 4) != 0) ? legal_ops[$urandom_range(0, 4)] : OW'($urandom_range(0, 15));
        end
        set_req(i[0], hv[i], ha[i], hb[i], hop[i]);
      end
      rr = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      bus.rsp0_ready = rr[0];
      bus.rsp1_ready = rr[1];
      #1;
      exp_rdy = 2'b00;
      winner  = 1'b0;
      if (!outst && (hv[0] || hv[1])) begin
        if (hv[0] && hv[1]) winner = prio;
        else                winner = hv[1];
        exp_rdy = onehot(winner);
      end
      chk("rnd_ready", ready_vec(), exp_rdy);
      chk("rnd_rspv", rspv_vec(), (outst && age >= 2) ? onehot(owner) : 2'b00);
      if (outst && age == 1) begin
        chk("rnd_alu_a", bus.alu_a, ea);
        chk("rnd_alu_b", bus.alu_b, eb);
        chk("rnd_alu_ctrl", bus.alu_ctrl, eop);
      end
      if (outst && age >= 2) check_rsp("rnd", owner, er, ez, ee);
      if (outst) begin
        if (age >= 2 && rr[owner]) begin
          outst = 1'b0;
          prio  = !owner;
        end else begin
          age++;
        end
      end else if (exp_rdy != 2'b00) begin
        outst = 1'b1;
        owner = winner;
        age   = 1;
        ea = ha[winner]; eb = hb[winner]; eop = hop[winner];
        ref_op(eop, ea, eb, er, ez, ee);
        hv[winner] = 1'b0;
      end
    end

    @(negedge clk);
    clear_inputs();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU instance between two requesters, e.g. the integer datapath and an address/branch-compare unit.
- Each requester offers an operand pair plus a 4-bit ALU control code over a valid/ready handshake.
- The block arbitrates round-robin, sequences the ALU through a registered execute step, and returns result, zero flag and error flag over a per-requester response handshake with backpressure.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath.
- OPW, 4, ALU control code width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  OPW  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp0_valid  out  1  response for requester 0 is available.
- rsp0_ready  in  1  requester 0 takes the response.
- rsp0_result  out  WIDTH  result for requester 0.
- rsp0_zero  out  1  zero flag for requester 0.
- rsp0_err  out  1  illegal op flag for requester 0.
- rsp1_valid, rsp1_ready, rsp1_result, rsp1_zero, rsp1_err: same as requester 0, for requester 1.
- alu_a, alu_b  out  WIDTH  operands driven to the shared ALU.
- alu_ctrl  out  OPW  control code driven to the shared ALU.
- alu_result  in  WIDTH  ALU result (combinational).
- alu_zero  in  1  ALU zero flag (combinational).

Behaviour:
- Legal codes:
  - 0010 add.
  - 0110 sub.
  - 0000 and.
  - 0001 or.
  - 0111 slt (unsigned compare, result 1 or 0).
  - Any other code is illegal.
- FSM states IDLE, EXEC, RESP. Reset enters IDLE.
- Reset values:
  - all ready and valid outputs 0; result, zero and err 0.
  - alu_a, alu_b and alu_ctrl 0.
  - grant register 0; round-robin pointer selects requester 0 as first priority.
- IDLE:
  - If any reqN_valid is high, pick a winner: the single requester if only one is valid; if both are valid, the requester not served last.
  - reqN_ready is asserted combinationally for the winner only, in that same cycle.
  - On the edge: capture a, b, op and the winner id into operand registers, then go to EXEC.
  - The loser's ready stays 0; it must hold valid and payload stable.
- EXEC (1 cycle):
  - alu_a, alu_b and alu_ctrl are driven from the operand registers (registered outputs, stable for the whole cycle).
  - On the edge, capture alu_result and alu_zero into the response registers, with err=0.
  - If the op is illegal, capture result=0, zero=0 and err=1 instead; the ALU output is ignored.
  - Go to RESP.
- RESP:
  - rspW_valid is high for the winner only; result, zero and err are stable while valid is high.
  - When rspW_ready is high, the response completes on that edge: go to IDLE and set the round-robin pointer to the other requester.
  - No new request is accepted in the completing cycle.
- Latency: accept at edge N; rsp_valid is high from cycle N+2 at the earliest. Minimum 3 cycles per operation with no backpressure.
- Backpressure: RESP holds indefinitely while rsp_ready is low. Both reqN_ready stay 0 for the whole time.
- rsp_ready for the non-winner and while not in RESP is ignored.
- The pointer changes only on response completion. Single-requester traffic is never throttled by the pointer.
- Simultaneous new request and response completion: the request waits one cycle and is accepted in IDLE.
- Reset in any state:
  - The in-flight operation is dropped and no response is issued.
  - All outputs return to reset values on that edge; the pointer resets.
- Outside EXEC, alu_a, alu_b and alu_ctrl hold their last values (no toggling).

Test Plan:
- Single add: req0 a=5, b=7, op=0010 -> req0_ready pulses 1 cycle; rsp0_valid 2 cycles later with result=12, zero=0, err=0.
- Sub to zero: req1 a=9, b=9, op=0110 -> rsp1 result=0, zero=1; rsp0_valid stays 0 throughout.
- Contention: both valid from reset (req0 or 0xF0|0x0F, req1 slt 3<4), rsp_ready tied 1 -> req0 is served first with result 0xFF. req1 is served next with result 1. Then each is re-asserted, and the grants alternate 0,1,0,1.
- Backpressure: req0 and 0xFF00 & 0x0FF0, rsp0_ready low for 5 cycles -> rsp0_valid high and result=0x0F00 stable for all 5 cycles. req1_ready stays 0 meanwhile; completion happens when rsp0_ready rises.
- Illegal op: req0 op=1111, a=1, b=2 -> rsp0 result=0, zero=0, err=1; the next legal op on req0 returns err=0.
- Reset mid-op: assert reset in EXEC -> no rsp valid follows and all outputs are 0 next cycle. After release, req1 alone is accepted immediately and requester 0 has priority under contention.
